regfile_wb_sink: RTL and testbench
==================================

Name: regfile_wb_sink

Overview:
- Architectural register file: 32 x 32-bit registers.
- Write side consumes the writeback-stage triple: write enable, 5-bit destination index, 32-bit data.
- Read side serves two operand ports to decode/execute.
- Also exposes $r30 ($rstatus) directly for bex/exception logic.
- Sits between the writeback stage and the decode stage of the 5-stage pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; index width is fixed at 5.
- RSTATUS_IDX, 30, index of the status/exception register exported on data_rstatus.

Ports:
- clock  in  1  single system clock; all writes occur on the rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- ctrl_writeEnable  in  1  commit data_writeReg into ctrl_writeReg at the next rising edge.
- ctrl_writeReg  in  5  destination register index from writeback (31 for jal, 30 for setx/exception).
- data_writeReg  in  DATA_W  writeback data (ALU result or load data).
- ctrl_readRegA  in  5  read port A index.
- ctrl_readRegB  in  5  read port B index.
- data_readRegA  out  DATA_W  contents of register ctrl_readRegA.
- data_readRegB  out  DATA_W  contents of register ctrl_readRegB.
- data_rstatus  out  DATA_W  contents of register RSTATUS_IDX.
- wr_count  out  16  count of committed (non-$r0) writes since reset; diagnostic only.

Behaviour:
- Reset:
  - ctrl_reset high asynchronously clears all registers and wr_count to 0.
  - All read outputs become 0 combinationally.
  - While reset is asserted, writes are ignored.
  - Reset deasserting mid-cycle: the first write accepted is at the first rising edge with ctrl_reset low.
- Write:
  - At the rising edge, if ctrl_writeEnable=1 and ctrl_writeReg!=0, reg[ctrl_writeReg] <= data_writeReg.
  - Exactly one register changes per edge; write latency is 1 edge.
- $r0:
  - Hardwired to zero. Writes to index 0 are discarded and do not increment wr_count.
  - Reads of index 0 always return 0, including under bypass.
- Read:
  - Fully combinational; no clock latency.
  - Both ports may address the same register; both return identical data.
- wr_count:
  - Increments by 1 on each accepted write.
  - Wraps from 16'hFFFF to 0 with no saturation.
- data_rstatus: always reflects reg[RSTATUS_IDX], with the same bypass rule as the read ports.
- Simultaneous read and write of the same index in one cycle: see Optional Feature.
- No state machine beyond the storage array and counter; no backpressure. The writeback stage never stalls on this block.

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- Defined:
  - Read ports and data_rstatus forward data_writeReg combinationally when ctrl_writeEnable=1, the addressed index equals ctrl_writeReg, and the index is not 0.
  - This gives write-before-read semantics inside one cycle, so the pipeline needs no W->D forwarding path.
- Undefined:
  - Reads return the pre-edge stored value.
  - The new value is visible only after the rising edge; decode must handle the W->D hazard by stalling or external bypass.
- Storage, $r0 rules and wr_count are identical in both builds.

Test Plan:
- Reset check: assert ctrl_reset mid-cycle after writing 0xDEADBEEF to $r5 -> data_readRegA (idx 5)=0 immediately without waiting for a clock edge; wr_count=0.
- Write/read all registers: write value idx*0x01010101 to idx 1..31 on consecutive edges, then sweep both ports.
  - Required: every register reads back its value.
  - Required: idx 0 reads 0.
  - Required: wr_count=31.
- $r0 protection: write 0xFFFFFFFF to idx 0 with enable high -> port A/B at idx 0 read 0; wr_count unchanged.
- Enable low: ctrl_writeEnable=0, ctrl_writeReg=7, data=0x12345678 -> $r7 keeps its prior value after the edge.
- Same-cycle read/write: $r30 holds 0x1; write 0x3 to idx 30 while both ports and data_rstatus observe idx 30.
  - With REGFILE_WRITE_BYPASS_EN: reads 0x3 before the edge.
  - Without it: reads 0x1 before the edge and 0x3 after.
- Counter wrap: preload via 65535 writes to idx 3 -> wr_count=0xFFFF; one more write -> wr_count=0x0000; $r3 holds the last data.

Source files
------------

// File: rtl/regfile_wb_sink.sv
// Architectural register file (32 x 32) fed by writeback, two combinational read ports plus $rstatus.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writeback data to the read ports and data_rstatus.
module regfile_wb_sink #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int RSTATUS_IDX = 30
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [4:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [4:0]        ctrl_readRegA,
  input  logic [4:0]        ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic [DATA_W-1:0] data_rstatus,
  output logic [15:0]       wr_count
);

  localparam logic [4:0] RSTATUS_SEL = 5'(RSTATUS_IDX);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              wr_accept;

  // $r0 is never written; out-of-range indices are dropped as well.
  assign wr_accept = ctrl_writeEnable && !ctrl_reset && (ctrl_writeReg != 5'd0)
                     && (int'(ctrl_writeReg) < NUM_REGS);
  assign wr_count_d = wr_count_q + 16'd1;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else if (wr_accept) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
      wr_count_q            <= wr_count_d;
    end
  end

  logic [DATA_W-1:0] rd_a_d;
  logic [DATA_W-1:0] rd_b_d;
  logic [DATA_W-1:0] rd_s_d;

  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    rd_s_d = '0;
    if (!ctrl_reset) begin
      if (ctrl_readRegA != 5'd0 && int'(ctrl_readRegA) < NUM_REGS) rd_a_d = regs_q[ctrl_readRegA];
      if (ctrl_readRegB != 5'd0 && int'(ctrl_readRegB) < NUM_REGS) rd_b_d = regs_q[ctrl_readRegB];
      if (RSTATUS_SEL != 5'd0 && RSTATUS_IDX < NUM_REGS) rd_s_d = regs_q[RSTATUS_SEL];
`ifdef REGFILE_WRITE_BYPASS_EN
      // wr_accept already excludes index 0, so $r0 never picks up bypass data.
      if (wr_accept && ctrl_readRegA == ctrl_writeReg) rd_a_d = data_writeReg;
      if (wr_accept && ctrl_readRegB == ctrl_writeReg) rd_b_d = data_writeReg;
      if (wr_accept && RSTATUS_SEL == ctrl_writeReg)   rd_s_d = data_writeReg;
`endif
    end
  end

  assign data_readRegA = rd_a_d;
  assign data_readRegB = rd_b_d;
  assign data_rstatus  = rd_s_d;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed self-checking bench for regfile_wb_sink; expectations follow REGFILE_WRITE_BYPASS_EN if defined.
module tb_regfile_wb_sink;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic [31:0] data_rstatus;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  regfile_wb_sink dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .data_rstatus     (data_rstatus),
    .wr_count         (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = idx;
    data_writeReg    = val;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0 || data_rstatus !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got A=%h B=%h S=%h exp 0", data_readRegA, data_readRegB, data_rstatus);
    end
    checks++;
    if (wr_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_count got=%h exp=0000", wr_count);
    end
    // writes while reset is held are ignored
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hA5A5A5A5;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    @(negedge clock);
    ctrl_reset = 1'b0;
    ctrl_readRegA = 5'd9;
    #1;
    checks++;
    if (data_readRegA !== 32'h0 || wr_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_ignores_write got r9=%h cnt=%h exp 0/0", data_readRegA, wr_count);
    end
    write_reg(5'd5, 32'hDEADBEEF);
    ctrl_readRegA = 5'd5;
    #1;
    checks++;
    if (data_readRegA !== 32'hDEADBEEF || wr_count !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset_write got r5=%h cnt=%h exp deadbeef/0001", data_readRegA, wr_count);
    end
    #1;
    ctrl_reset = 1'b1;
    #1;
    checks++;
    if (data_readRegA !== 32'h0 || wr_count !== 16'h0) begin
      failures++;
      $display("FAIL async_reset got r5=%h cnt=%h exp 0/0", data_readRegA, wr_count);
    end
    @(negedge clock);
    ctrl_reset = 1'b0;
  endtask

  task automatic test_write_all;
    logic [31:0] exp_a, exp_b;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      exp_a = 32'(i) * 32'h01010101;
      exp_b = 32'(31 - i) * 32'h01010101;
      checks++;
      if (data_readRegA !== exp_a || data_readRegB !== exp_b) begin
        failures++;
        $display("FAIL sweep idx=%0d got A=%h B=%h exp A=%h B=%h", i, data_readRegA, data_readRegB, exp_a, exp_b);
      end
    end
    checks++;
    if (data_rstatus !== 32'h1E1E1E1E) begin
      failures++;
      $display("FAIL rstatus_sweep got=%h exp=1e1e1e1e", data_rstatus);
    end
    checks++;
    if (wr_count !== 16'd31) begin
      failures++;
      $display("FAIL count_after_sweep got=%0d exp=31", wr_count);
    end
  endtask

  task automatic test_r0;
    @(negedge clock);
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFFFFFF;
    #1;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      failures++;
      $display("FAIL r0_pre_edge got A=%h B=%h exp 0", data_readRegA, data_readRegB);
    end
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0 || wr_count !== 16'd31) begin
      failures++;
      $display("FAIL r0_post_edge got A=%h B=%h cnt=%0d exp 0/0/31", data_readRegA, data_readRegB, wr_count);
    end
  endtask

  task automatic test_enable_low;
    @(negedge clock);
    ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
    ctrl_writeEnable = 1'b0; ctrl_writeReg = 5'd7; data_writeReg = 32'h12345678;
    #1;
    checks++;
    if (data_readRegA !== 32'h07070707) begin
      failures++;
      $display("FAIL enable_low_pre got=%h exp=07070707", data_readRegA);
    end
    @(posedge clock);
    #1;
    checks++;
    if (data_readRegA !== 32'h07070707 || data_readRegB !== 32'h07070707 || wr_count !== 16'd31) begin
      failures++;
      $display("FAIL enable_low_post got A=%h B=%h cnt=%0d exp 07070707/07070707/31", data_readRegA, data_readRegB, wr_count);
    end
  endtask

  task automatic test_same_cycle;
    logic [31:0] exp_pre;
    write_reg(5'd30, 32'h1);
    @(negedge clock);
    ctrl_readRegA = 5'd30; ctrl_readRegB = 5'd30;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd30; data_writeReg = 32'h3;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_pre = 32'h3;
`else
    exp_pre = 32'h1;
`endif
    checks++;
    if (data_readRegA !== exp_pre || data_readRegB !== exp_pre || data_rstatus !== exp_pre) begin
      failures++;
      $display("FAIL same_cycle_pre got A=%h B=%h S=%h exp=%h", data_readRegA, data_readRegB, data_rstatus, exp_pre);
    end
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    checks++;
    if (data_readRegA !== 32'h3 || data_readRegB !== 32'h3 || data_rstatus !== 32'h3 || wr_count !== 16'd33) begin
      failures++;
      $display("FAIL same_cycle_post got A=%h B=%h S=%h cnt=%0d exp 3/3/3/33", data_readRegA, data_readRegB, data_rstatus, wr_count);
    end
  endtask

  task automatic test_back_to_back;
    write_reg(5'd12, 32'h11112222);
    write_reg(5'd13, 32'h33334444);
    write_reg(5'd12, 32'h55556666);
    ctrl_readRegA = 5'd12; ctrl_readRegB = 5'd13;
    #1;
    checks++;
    if (data_readRegA !== 32'h55556666 || data_readRegB !== 32'h33334444 || wr_count !== 16'd36) begin
      failures++;
      $display("FAIL back_to_back got A=%h B=%h cnt=%0d exp 55556666/33334444/36", data_readRegA, data_readRegB, wr_count);
    end
  endtask

  task automatic test_wrap;
    @(negedge clock);
    ctrl_reset = 1'b1;
    #1;
    ctrl_reset = 1'b0;
    ctrl_readRegA = 5'd3;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3;
    for (int i = 1; i <= 65535; i++) begin
      data_writeReg = 32'(i);
      @(posedge clock);
      @(negedge clock);
    end
    ctrl_writeEnable = 1'b0;
    #1;
    checks++;
    if (wr_count !== 16'hFFFF || data_readRegA !== 32'd65535) begin
      failures++;
      $display("FAIL wrap_preload got cnt=%h r3=%h exp ffff/0000ffff", wr_count, data_readRegA);
    end
    write_reg(5'd3, 32'hCAFE0003);
    checks++;
    if (wr_count !== 16'h0000 || data_readRegA !== 32'hCAFE0003) begin
      failures++;
      $display("FAIL wrap got cnt=%h r3=%h exp 0000/cafe0003", wr_count, data_readRegA);
    end
  endtask

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd5;
    ctrl_readRegB    = 5'd0;
    #12;
    test_reset;
    test_write_all;
    test_r0;
    test_enable_low;
    test_same_cycle;
    test_back_to_back;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
